button_conditioner: RTL
=======================

# button_conditioner

Front-end input stage for the seven quiz buttons: synchronises the raw pushbutton pins to `clk` and debounces each one. It emits a debounced level and a one-cycle press pulse per button, plus a single arbitrated press event carrying the button number (1..7). The level/pulse outputs feed the binary-quiz game FSM. Press lockout guarantees exactly one game input per physical press, even when several buttons are mashed.

## Interface
- `DEBOUNCE_CYCLES`, default 200_000: consecutive cycles a synchronised input must differ from its debounced level before the level flips (20 ms at 10 MHz). Legal range ≥ 1.
- `CNT_W`, default 18: per-button counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
- `clk`  in  1  system clock, 10 MHz nominal
- `reset`  in  1  reset, asynchronous, active-high; clock clk
- `btn_raw`  in  7  raw button pins, bit i = button i+1, active-high, asynchronous to clk
- `btn_level`  out  7  debounced level per button
- `btn_pulse`  out  7  one-cycle pulse on each debounced 0→1 transition
- `press_valid`  out  1  one-cycle strobe: an accepted, arbitrated press
- `press_code`  out  3  button number (1..7) of the last accepted press; 0 after reset

## Operation
- Synchroniser: two flops per bit, `s1 <= btn_raw`, `s2 <= s1`. No logic between them.
- Debounce, per bit i, state `btn_level[i]` and `cnt[i]`:
  - `s2[i] == btn_level[i]`: `cnt[i] <= 0`.
  - Differ and `cnt[i] == DEBOUNCE_CYCLES-1`: `btn_level[i] <= s2[i]`, `cnt[i] <= 0`.
  - Differ otherwise: `cnt[i] <= cnt[i]+1`.
  - Any agreement during counting (a glitch) restarts the count from 0.
  - Release is debounced identically to press.
- Pulse: `btn_pulse[i]` is a register, set to 1 on the same edge `btn_level[i]` goes 0→1, cleared on the next edge. Releases produce no pulse.
- Arbitration/lockout, with an internal `lock` bit:
  - `lock==0` and any `btn_pulse` bit high: on the next edge `press_valid <= 1`, `press_code <=` (lowest set index)+1, `lock <= 1`.
  - `lock==1`: pulses are ignored and `press_valid` stays 0. `btn_pulse` and `btn_level` still report normally.
  - `lock` clears on the edge where `btn_level == 0` for all bits, observed while `press_valid` is 0.
  - `press_valid` is otherwise 0. `press_code` holds between events.
- Simultaneous pulses in one cycle produce a single event; the lowest button number wins.
- Reset values: `s1`, `s2`, `cnt`, `btn_level`, `btn_pulse`, `press_valid`, `lock` = 0; `press_code` = 3'd0.
- Reset mid-press: all state clears. A button still held after reset release re-debounces and produces a fresh pulse and event.

## Timing
- Raw change set up before edge 1, held stable:
  - `s2` updates at edge 2.
  - `btn_level` and `btn_pulse` update at edge DEBOUNCE_CYCLES+2.
  - `press_valid` is asserted for the cycle after edge DEBOUNCE_CYCLES+3.
- Release: `btn_level` falls DEBOUNCE_CYCLES+2 edges after raw falls. `lock` clears 1 edge after the last level falls.
- `btn_pulse` and `press_valid` are exactly one cycle wide. Minimum spacing between two events is set by the full release plus re-press debounce.
- All outputs are registered; there is no combinational path from `btn_raw`.

## Test plan
- Clean press, bench uses DEBOUNCE_CYCLES=4:
  - Stimulus: raw bit 2 rises before edge 1 and is held 20 cycles.
  - Required: `btn_level[2]`=1 and `btn_pulse[2]`=1 after edge 6; pulse=0 after edge 7.
  - Required: `press_valid`=1 after edge 7 only; `press_code`=3.
- Bounce:
  - Stimulus: bit 0 toggles 1,0,1,0 at 2-cycle intervals, then holds 1.
  - Required: no level change until 4 consecutive differing `s2` samples; exactly one pulse; `press_code`=1.
- Simultaneous: bits 1 and 5 rise in the same cycle → `btn_pulse`=7'b0100010 for one cycle; one `press_valid`; `press_code`=2.
- Lockout:
  - Stimulus: hold bit 3; 10 cycles later press bit 6.
  - Required: `btn_pulse[6]` fires but no second `press_valid`.
  - Stimulus: release both, wait for levels to reach 0, press bit 6.
  - Required: `press_valid` with `press_code`=7.
- Reset mid-operation:
  - Stimulus: assert reset while bit 4 is debounced high and `lock`=1.
  - Required: all outputs 0 asynchronously.
  - Stimulus: release reset with bit 4 still held.
  - Required: new pulse after DEBOUNCE_CYCLES+2 edges and `press_valid` with `press_code`=5.
- Release debounce: after a held press, drop raw → `btn_level` falls after DEBOUNCE_CYCLES+2 edges with no pulse and no `press_valid`.

Source files
------------

// File: rtl/button_conditioner.sv
// Seven-button input stage: two-flop synchroniser, per-button debounce with
// press pulse, and a locked-out arbiter that emits one coded event per press.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 200_000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] btn_raw,
  output logic [6:0] btn_level,
  output logic [6:0] btn_pulse,
  output logic       press_valid,
  output logic [2:0] press_code
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [6:0] s1;
  logic [6:0] s2;
  logic       lock;
  logic [2:0] first_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt;
      logic             level;
      logic             pulse;

      // Any cycle where the synchronised input agrees with the level restarts the count.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt   <= '0;
          level <= 1'b0;
          pulse <= 1'b0;
        end else begin
          pulse <= 1'b0;
          if (s2[gi] == level) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            level <= s2[gi];
            pulse <= s2[gi];
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign btn_level[gi] = level;
      assign btn_pulse[gi] = pulse;
    end
  endgenerate

  // Lowest pulsing button wins when several debounce on the same cycle.
  always_comb begin
    first_code = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (btn_pulse[i]) first_code = 3'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_valid <= 1'b0;
      press_code  <= 3'd0;
      lock        <= 1'b0;
    end else begin
      press_valid <= 1'b0;
      if (!lock && (btn_pulse != 7'd0)) begin
        press_valid <= 1'b1;
        press_code  <= first_code;
        lock        <= 1'b1;
      end else if (lock && !press_valid && (btn_level == 7'd0)) begin
        lock <= 1'b0;
      end
    end
  end

endmodule
